// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for the 4-bit counter datapath: counts 0..limit in one-shot
// or auto-reload mode, with pause/abort, and emits terminal-count and completion strobes.
module counter_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode_auto,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lim_q;

    // abort wins over everything; terminal handling wins over pause inside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            lim_q <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (abort) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (limit != '0) begin
                                lim_q <= limit;
                                count <= '0;
                                state <= RUN;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (count == lim_q) begin
                            if (mode_auto) begin
                                count <= '0;
                                state <= pause ? PAUSE : RUN;
                            end else begin
                                state <= DONE;
                            end
                        end else if (pause) begin
                            state <= PAUSE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (!pause) state <= RUN;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state == RUN) || (state == PAUSE);
    assign tc   = (state == RUN) && (count == lim_q);
    assign done = (state == DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: randomized limits, modes and pause patterns
// compared against expected count sequences derived from the counting rules.
module tb_counter_seq_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       start     = 1'b0;
    logic [3:0] limit     = 4'd0;
    logic       mode_auto = 1'b0;
    logic       pause     = 1'b0;
    logic       abort     = 1'b0;
    logic [3:0] count;
    logic       busy, tc, done, err;

    int         nTests = 0;
    int         nFail  = 0;
    logic [3:0] lastCount = 4'd0;
    logic [7:0] got;
    logic [7:0] exp;

    counter_seq_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .limit(limit),
        .mode_auto(mode_auto), .pause(pause), .abort(abort),
        .count(count), .busy(busy), .tc(tc), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        got = {busy, tc, done, err, count};
        exp = 8'b0000_0000;
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL reset_assert: busy/tc/done/err/count got %b expected %b", got, exp);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick;
        got = {busy, tc, done, err, count};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL reset_release: busy/tc/done/err/count got %b expected %b", got, exp);
        end
        lastCount = 4'd0;
    endtask

    task automatic test_oneshot(input int L);
        start = 1'b1; limit = 4'(L); mode_auto = 1'b0;
        tick;
        start = 1'b0;
        for (int k = 0; k <= L; k++) begin
            got = {busy, tc, done, err, count};
            exp = {1'b1, (k == L), 1'b0, 1'b0, 4'(k)};
            nTests++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL oneshot L=%0d k=%0d: got %b expected %b", L, k, got, exp);
            end
            limit = 4'($urandom);
            start = 1'($urandom_range(0, 1));
            tick;
        end
        start = 1'b0;
        got = {busy, tc, done, err, count};
        exp = {4'b0010, 4'(L)};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL oneshot_done L=%0d: got %b expected %b", L, got, exp);
        end
        tick;
        got = {busy, tc, done, err, count};
        exp = {4'b0000, 4'(L)};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL oneshot_idle L=%0d: got %b expected %b", L, got, exp);
        end
        lastCount = 4'(L);
    endtask

    task automatic test_err;
        start = 1'b1; limit = 4'd0;
        tick;
        start = 1'b0;
        got = {busy, tc, done, err, count};
        exp = {4'b0001, lastCount};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL err_strobe: got %b expected %b", got, exp);
        end
        tick;
        got = {busy, tc, done, err, count};
        exp = {4'b0000, lastCount};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL err_clear: got %b expected %b", got, exp);
        end
    endtask

    task automatic test_auto(input int L, input int n);
        start = 1'b1; limit = 4'(L); mode_auto = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            got = {busy, tc, done, err, count};
            exp = {1'b1, ((k % (L + 1)) == L), 1'b0, 1'b0, 4'(k % (L + 1))};
            nTests++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL auto L=%0d k=%0d: got %b expected %b", L, k, got, exp);
            end
            limit = 4'($urandom);
            tick;
        end
        abort = 1'b1;
        tick;
        abort = 1'b0; mode_auto = 1'b0;
        got = {busy, tc, done, err, count};
        exp = 8'b0000_0000;
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL auto_abort L=%0d: got %b expected %b", L, got, exp);
        end
        lastCount = 4'd0;
    endtask

    // Reference model: position along 0..L plus a paused flag, advanced per edge
    task automatic test_pause(input int L, input bit scripted);
        int  expCnt    = 0;
        bit  expPaused = 1'b0;
        bit  finished  = 1'b0;
        bit  p;
        start = 1'b1; limit = 4'(L); mode_auto = 1'b0;
        tick;
        start = 1'b0;
        for (int t = 0; t < 300 && !finished; t++) begin
            got = {busy, tc, done, err, count};
            exp = {1'b1, (!expPaused && expCnt == L), 1'b0, 1'b0, 4'(expCnt)};
            nTests++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL pause L=%0d t=%0d: got %b expected %b", L, t, got, exp);
            end
            p = scripted ? (t >= 4 && t <= 6) : ($urandom_range(0, 3) == 0);
            pause = p;
            tick;
            if (expPaused)          expPaused = p;
            else if (expCnt == L)   finished = 1'b1;
            else if (p)             expPaused = 1'b1;
            else                    expCnt++;
        end
        pause = 1'b0;
        got = {busy, tc, done, err, count};
        exp = {4'b0010, 4'(L)};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL pause_done L=%0d: got %b expected %b", L, got, exp);
        end
        tick;
        got = {busy, tc, done, err, count};
        exp = {4'b0000, 4'(L)};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL pause_idle L=%0d: got %b expected %b", L, got, exp);
        end
        lastCount = 4'(L);
    endtask

    task automatic test_abort;
        start = 1'b1; limit = 4'd15; mode_auto = 1'b0;
        tick;
        start = 1'b0;
        repeat (6) tick;
        got = {busy, tc, done, err, count};
        exp = {4'b1000, 4'd6};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL abort_pre: got %b expected %b", got, exp);
        end
        abort = 1'b1;
        tick;
        got = {busy, tc, done, err, count};
        exp = 8'b0000_0000;
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL abort_idle: got %b expected %b", got, exp);
        end
        start = 1'b1; limit = 4'd5;
        tick;
        got = {busy, tc, done, err, count};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL abort_with_start: got %b expected %b", got, exp);
        end
        abort = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            got = {busy, tc, done, err, count};
            nTests++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL abort_after i=%0d: got %b expected %b", i, got, exp);
            end
        end
        lastCount = 4'd0;
    endtask

    task automatic test_back_to_back(input int L);
        start = 1'b1; limit = 4'(L); mode_auto = 1'b0;
        tick;
        for (int k = 0; k <= L; k++) begin
            got = {busy, tc, done, err, count};
            exp = {1'b1, (k == L), 1'b0, 1'b0, 4'(k)};
            nTests++;
            if (got !== exp) begin
                nFail++;
                $display("[TB] FAIL b2b L=%0d k=%0d: got %b expected %b", L, k, got, exp);
            end
            tick;
        end
        got = {busy, tc, done, err, count};
        exp = {4'b0010, 4'(L)};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL b2b_done L=%0d: got %b expected %b", L, got, exp);
        end
        tick;
        got = {busy, tc, done, err, count};
        exp = {4'b0000, 4'(L)};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL b2b_idle L=%0d: got %b expected %b", L, got, exp);
        end
        tick;
        got = {busy, tc, done, err, count};
        exp = {4'b1000, 4'd0};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL b2b_restart L=%0d: got %b expected %b", L, got, exp);
        end
        start = 1'b0; abort = 1'b1;
        tick;
        abort = 1'b0;
        lastCount = 4'd0;
    endtask

    task automatic test_async_reset;
        start = 1'b1; limit = 4'd15; mode_auto = 1'b0;
        tick;
        start = 1'b0;
        repeat (7) tick;
        got = {busy, tc, done, err, count};
        exp = {4'b1000, 4'd7};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL async_pre: got %b expected %b", got, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {busy, tc, done, err, count};
        exp = 8'b0000_0000;
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL async_reset: got %b expected %b", got, exp);
        end
        #2 rst_n = 1'b1;
        tick;
        got = {busy, tc, done, err, count};
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL async_release: got %b expected %b", got, exp);
        end
        lastCount = 4'd0;
    endtask

    initial begin
        test_reset;
        test_oneshot(5);
        test_oneshot(15);
        for (int i = 0; i < 4; i++) test_oneshot($urandom_range(1, 15));
        test_err;
        test_oneshot(2);
        test_auto(3, 12);
        for (int i = 0; i < 2; i++) test_auto($urandom_range(1, 15), $urandom_range(20, 40));
        test_pause(9, 1'b1);
        for (int i = 0; i < 3; i++) test_pause($urandom_range(1, 15), 1'b0);
        test_abort;
        test_back_to_back($urandom_range(1, 15));
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencing controller for the team's 4-bit synchronous counter datapath.
- Runs a programmable-length count from 0 up to a latched limit, in one-shot or auto-reload mode, with pause and abort.
- Produces terminal-count and completion strobes for downstream timing logic.
- Sits between the control/config logic and the counter; owns the counter state register.

Parameters:
WIDTH, 4, counter/limit width in bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled request to begin a count; honoured only in IDLE
limit  input  WIDTH  terminal value; latched on accepted start
mode_auto  input  1  1 = reload to 0 at terminal count and keep running; 0 = one-shot; sampled every RUN cycle
pause  input  1  hold count while high (RUN<->PAUSE)
abort  input  1  synchronous return to IDLE, highest priority
count  output  WIDTH  current count value (registered)
busy  output  1  high in RUN or PAUSE
tc  output  1  terminal-count strobe
done  output  1  one-shot completion strobe, one cycle
err  output  1  one-cycle strobe: start rejected because limit==0

Behaviour:
- Interface: single clock clk; reset rst_n asynchronous, active-low.
- Reset (rst_n=0, immediate, independent of clk): state=IDLE, count=0, lim_q=0, err=0.
  - busy, tc and done follow from state and are therefore 0.
- States: IDLE, RUN, PAUSE, DONE. All transitions occur on the rising edge of clk.
- Decoded outputs (from registers only, no input paths):
  - busy = (state==RUN)|(state==PAUSE).
  - tc = (state==RUN)&&(count==lim_q).
  - done = (state==DONE).
  - err is a registered output.
- Priority each edge: abort > terminal-count handling > pause > increment.
- abort=1 in any state: next state=IDLE, count<=0, err<=0. Abort mid-count discards progress; no done or tc follows.
- IDLE:
  - start=1 and limit!=0: lim_q<=limit, count<=0, next=RUN.
  - start=1 and limit==0: err<=1 for one cycle, remain IDLE, count unchanged.
  - Otherwise hold. count retains its last value in IDLE (lim_q after one-shot completion, 0 after reset or abort).
- RUN, count!=lim_q:
  - pause=0: count<=count+1.
  - pause=1: next=PAUSE, count held.
- RUN, count==lim_q (tc=1 this cycle):
  - mode_auto=1: count<=0, next=RUN; if pause=1, next=PAUSE with count 0.
  - mode_auto=0: count held at lim_q, next=DONE. pause is ignored.
- PAUSE: count held, tc=0. pause=0 -> next=RUN. start ignored.
- DONE: lasts exactly one cycle, then IDLE. start in DONE is ignored; it must be re-sampled in IDLE.
- start in RUN/PAUSE is ignored. limit changes after acceptance have no effect until the next accepted start.
- Timing for latched limit L, no pause:
  - Accepted-start edge -> RUN with count=0.
  - count reaches L after L further edges; tc high for that one cycle.
  - One-shot: done high the following cycle.
  - RUN lasts L+1 cycles in total.
- Arithmetic: count is an unsigned WIDTH-bit value. The count<=lim_q invariant holds, so no natural wrap occurs in RUN. Reload to 0 happens only via terminal handling.
- Reset asserted mid-RUN: all state is cleared immediately; operation resumes from IDLE after release.

Test Plan:
- Reset then start=1 one cycle, limit=5, mode_auto=0 -> count 0,1,2,3,4,5 on consecutive cycles; tc=1 only at count=5; done=1 the next cycle; then IDLE with count=5 and busy=0.
- limit=3, mode_auto=1, start, run 12 cycles -> count 0,1,2,3,0,1,2,3,...; tc every 4th cycle; done never asserted; busy stays 1.
- limit=9, one-shot, pause=1 for 3 cycles while count=4 -> state PAUSE, count holds at 4 for 3 cycles with tc=0; resume 5..9; tc at 9; done next cycle.
- start with limit=0 -> err=1 for exactly one cycle, busy=0, state stays IDLE; a following start with limit=2 runs normally.
- abort=1 at count=6 (limit=15) -> next cycle IDLE, count=0, no tc or done; abort and start together in IDLE -> stays IDLE.
- limit=15 (max) one-shot -> counts 0..15 with no overflow; tc at 15. Assert rst_n=0 asynchronously mid-count at count=7 -> outputs clear immediately, without waiting for a clock edge.
